// File: rtl/wisc_pkg.sv
// Shared types and default widths for the processor's memory stage.
// Imported by mem_access_ctrl; mem_watchdog is self-contained.
package wisc_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int ADDR_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } mem_state_t;

    // A request is illegal when the byte address is odd or both strobes are set.
    function automatic logic access_illegal(input logic addr_lsb,
                                            input logic rd,
                                            input logic wr);
        return addr_lsb | (rd & wr);
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive enabled cycles and flags the LIMIT-th one.
// Only instantiated by mem_access_ctrl when MEM_TIMEOUT_EN is defined.
module mem_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count;

    // Combinational so the controller can leave WAIT on the LIMIT-th cycle itself.
    assign expired = en & (count == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: one transaction per load/store, pipeline stall, sticky error.
// Optional watchdog on the WAIT state is enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl
    import wisc_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              Stall,
    output logic              Done,
    output logic [DATA_W-1:0] ReadData,
    output logic              err,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("mem_access_ctrl: TIMEOUT_CYC must be at least 2");
    end

    mem_state_t state;
    logic       stall_q;
    logic       req;
    logic       illegal;
    logic       timeout;

    assign req     = Valid & (MemRead | MemWrite);
    assign illegal = req & access_illegal(Addr[0], MemRead, MemWrite);

`ifdef MEM_TIMEOUT_EN
    mem_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state != WAIT),
        .en      (state == WAIT),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // NOTE: the IDLE term is combinational so the pipeline freezes in the same
    // cycle a request appears; every other stall comes from the stall_q register.
    assign Stall = stall_q | (rst_n & (state == IDLE) & req);

    // NOTE: state and outputs use non-blocking assignments so every register
    // samples the pre-edge values; reset is synchronous and clears all of them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            stall_q   <= 1'b0;
            Done      <= 1'b0;
            err       <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ReadData  <= '0;
        end else begin
            mem_en <= 1'b0;
            Done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (illegal) begin
                        state   <= ERR;
                        err     <= 1'b1;
                        stall_q <= 1'b1;
                    end else if (req) begin
                        state     <= REQ;
                        mem_en    <= 1'b1;
                        mem_wr    <= MemWrite;
                        mem_addr  <= Addr;
                        mem_wdata <= WriteData;
                        stall_q   <= 1'b1;
                    end
                end
                REQ, WAIT: begin
                    if (mem_done) begin
                        state    <= RESP;
                        Done     <= 1'b1;
                        stall_q  <= 1'b0;
                        ReadData <= mem_wr ? '0 : mem_rdata;
                    end else if (timeout) begin
                        state <= ERR;
                        err   <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                RESP: begin
                    // Pipeline advances on this edge; requests resume from IDLE.
                    state <= IDLE;
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state   <= IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected responses queued at issue, checked at Done.
module tb_mem_access_ctrl;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          Valid, MemRead, MemWrite;
    logic [AW-1:0] Addr;
    logic [DW-1:0] WriteData;
    logic          Stall, Done, err, mem_en, mem_wr;
    logic [DW-1:0] ReadData, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_done;

    typedef struct {
        logic [DW-1:0] rdata;
        int            stall;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Valid     (Valid),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .Stall     (Stall),
        .Done      (Done),
        .ReadData  (ReadData),
        .err       (err),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drop_inputs();
        Valid     = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Addr      = '0;
        WriteData = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, Stall, 0);
        check({tag, "_done"}, Done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_mem_en"}, mem_en, 0);
        check({tag, "_mem_wr"}, mem_wr, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_rdata"}, ReadData, 0);
    endtask

    // Called at posedge+1; returns at posedge+1 with the DUT idle.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero(tag);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One access through the memory model; mem_done arrives 'waits' cycles after mem_en.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             input logic [DW-1:0] rdv, input int waits);
        exp_t e;
        int   stall_cnt = 0;
        int   en_cnt    = 0;
        int   req_cyc   = -1;
        int   cyc       = 0;
        bit   done_seen = 1'b0;
        e.rdata = wr ? '0 : rdv;
        e.stall = 2 + waits;
        sb.push_back(e);
        Valid = 1'b1; MemRead = rd; MemWrite = wr; Addr = a; WriteData = wd;
        while (!done_seen && cyc < 200) begin
            @(negedge clk);
            if (Stall) stall_cnt++;
            if (mem_en) begin
                en_cnt++;
                req_cyc = cyc;
                check({tag, "_mem_wr"}, mem_wr, wr);
                check({tag, "_mem_addr"}, mem_addr, a);
                if (wr) check({tag, "_mem_wdata"}, mem_wdata, wd);
            end
            mem_done  = 1'b0;
            mem_rdata = '0;
            if (req_cyc >= 0 && (cyc - req_cyc) == waits) begin
                mem_done  = 1'b1;
                mem_rdata = rdv;
            end
            if (Done) begin
                done_seen = 1'b1;
                if (sb.size() == 0) begin
                    check({tag, "_sb_nonempty"}, 0, 1);
                end else begin
                    e = sb.pop_front();
                    check({tag, "_rdata"}, ReadData, e.rdata);
                    check({tag, "_stall_cycles"}, stall_cnt, e.stall);
                end
                check({tag, "_resp_stall"}, Stall, 0);
                drop_inputs();
            end
            cyc++;
        end
        mem_done = 1'b0;
        check({tag, "_done_seen"}, done_seen, 1);
        check({tag, "_mem_en_count"}, en_cnt, 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, Done, 0);
        check({tag, "_idle_stall"}, Stall, 0);
        @(posedge clk);
        #1;
    endtask

    // Drives a request and waits (bounded) for mem_en; leaves the caller at that negedge.
    task automatic issue_until_en(input string tag, input logic [AW-1:0] a);
        int k = 0;
        Valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Addr = a;
        do begin
            @(negedge clk);
            k++;
        end while (!mem_en && k < 10);
        check({tag, "_mem_en_seen"}, mem_en, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_done  = 1'b0;
        mem_rdata = '0;
        drop_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        do_access("ld_best",   1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 0);
        do_access("st_wait2",  1'b0, 1'b1, 16'h0020, 16'h1234, 16'hDEAD, 2);
        do_access("ld_wait1",  1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h5A5A, 1);
        do_access("st_best",   1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'h0F0F, 0);
        do_access("ld_wait5",  1'b1, 1'b0, 16'h8000, 16'h0000, 16'h0001, 5);

        // Misaligned load: straight to ERR, no memory access.
        Valid = 1'b1; MemRead = 1'b1; Addr = 16'h0011;
        @(negedge clk);
        check("mis_stall_idle", Stall, 1);
        check("mis_no_en", mem_en, 0);
        @(posedge clk);
        #1 drop_inputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mis_err_held", err, 1);
            check("mis_stall_held", Stall, 1);
            check("mis_no_en_held", mem_en, 0);
        end
        @(posedge clk);
        #1 do_reset("mis_reset");

        // Simultaneous read and write is illegal as well.
        Valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b1; Addr = 16'h0040;
        @(negedge clk);
        check("rw_no_en", mem_en, 0);
        @(posedge clk);
        #1 drop_inputs();
        @(negedge clk);
        check("rw_err", err, 1);
        check("rw_stall", Stall, 1);
        @(posedge clk);
        #1 do_reset("rw_reset");

        // Not valid: request strobes are ignored.
        MemRead = 1'b1; Addr = 16'h0060;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("novalid_stall", Stall, 0);
            check("novalid_en", mem_en, 0);
        end
        @(posedge clk);
        #1 drop_inputs();

        // Reset during WAIT drops the outstanding reply.
        issue_until_en("rstw", 16'h0030);
        @(negedge clk);
        check("rstw_wait_stall", Stall, 1);
        @(posedge clk);
        #1 do_reset("rstw_reset");
        drop_inputs();
        @(negedge clk);
        mem_done = 1'b1; mem_rdata = 16'hAAAA;
        @(negedge clk);
        mem_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstw_no_done", Done, 0);
            check("rstw_no_stall", Stall, 0);
        end
        @(posedge clk);
        #1;

        // Memory never answers.
        issue_until_en("hang", 16'h0050);
`ifdef MEM_TIMEOUT_EN
        begin
            int k = 0;
            while (!err && k < 50) begin
                @(negedge clk);
                k++;
            end
            check("timeout_cycles", k, TO + 1);
            check("timeout_stall", Stall, 1);
        end
`else
        repeat (100) @(negedge clk);
        check("hang_stall", Stall, 1);
        check("hang_no_err", err, 0);
        check("hang_no_done", Done, 0);
`endif
        @(posedge clk);
        #1 drop_inputs();
        do_reset("hang_reset");

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
